// File: rtl/axi_rd_if.sv
// axi_rd_if: AXI4 read-address and read-data channels between a read master and a memory slave.
interface axi_rd_if #(
  parameter int ID_WIDTH = 4,
  parameter int DATA_WIDTH = 128
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [3:0] arqos;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_bram_loader.sv
// axi_rd_bram_loader: fetches a contiguous block of words in fixed-length INCR bursts into the input BRAM.
// Define LOADER_RESP_CHECK_EN to flag RRESP errors and RLAST/beat-count mismatches on err.
module axi_rd_bram_loader #(
  parameter int M_AXI_ID_WIDTH = 4,
  parameter int M_AXI_DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 11,
  parameter int BURST_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [31:0] base_addr,
  input  logic [ADDR_WIDTH:0] num_beats,
  input  logic [ADDR_WIDTH-1:0] bram_base,
  output logic busy,
  output logic done,
  output logic err,
  axi_rd_if.master m_axi,
  output logic bram_we,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [M_AXI_DATA_WIDTH-1:0] bram_wdata
);
  localparam int RW = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
  state_t state, state_nx;
  logic [31:0] addr;
  logic [RW-1:0] remaining, cnt, len;
  logic [ADDR_WIDTH-1:0] wptr;
  logic accept, ar_hs, r_hs, last_cnt, last_beat;
  assign len = (remaining < RW'(BURST_LEN)) ? remaining : RW'(BURST_LEN);
  assign accept = (state == IDLE) && start;
  assign ar_hs = m_axi.arvalid && m_axi.arready;
  assign r_hs = m_axi.rvalid && m_axi.rready;
  assign last_cnt = cnt == len - RW'(1);
  assign last_beat = r_hs && last_cnt;
  assign m_axi.arid = '0;
  assign m_axi.arsize = 3'b100;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock = 1'b0;
  assign m_axi.arcache = 4'b0010;
  assign m_axi.arprot = 3'b000;
  assign m_axi.arqos = 4'b0000;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (num_beats == '0) ? FIN : ADDR;
      ADDR: if (ar_hs) state_nx = DATA;
      DATA: if (last_beat) state_nx = (remaining == len) ? FIN : ADDR;
      FIN:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    m_axi.arvalid = state == ADDR;
    m_axi.araddr = (state == ADDR) ? addr : '0;
    m_axi.arlen = (state == ADDR) ? 8'(len - RW'(1)) : '0;
    m_axi.rready = state == DATA;
    busy = state != IDLE;
  end
  // Burst end is counted locally; RLAST only feeds the optional error check.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      remaining <= '0;
      cnt <= '0;
      wptr <= '0;
      bram_we <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      done <= 1'b0;
    end else begin
      bram_we <= r_hs;
      done <= state == FIN;
      if (accept) begin
        addr <= {base_addr[31:4], 4'b0000};
        remaining <= num_beats;
        wptr <= bram_base;
      end
      if (ar_hs) cnt <= '0;
      if (r_hs) begin
        bram_waddr <= wptr;
        bram_wdata <= m_axi.rdata;
        wptr <= wptr + ADDR_WIDTH'(1);
        cnt <= cnt + RW'(1);
      end
      if (last_beat) begin
        addr <= addr + (32'(len) << 4);
        remaining <= remaining - len;
      end
    end
`ifdef LOADER_RESP_CHECK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (r_hs && ((m_axi.rresp != 2'b00) || (m_axi.rlast != last_cnt))) err <= 1'b1;
  logic unused_ok;
  assign unused_ok = ^{base_addr[3:0], m_axi.rid};
`else
  assign err = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{base_addr[3:0], m_axi.rid, m_axi.rresp, m_axi.rlast};
`endif
endmodule
